// File: rtl/serial_exec_unit_if.sv
// Instruction issue / status bundle for serial_exec_unit.
// master drives the instruction fields, slave reports progress and results.
interface serial_exec_unit_if #(
    parameter int WIDTH = 8,
    parameter int RW    = 2
);
    logic             start;
    logic [2:0]       op;
    logic [RW-1:0]    rd;
    logic [RW-1:0]    rs1;
    logic [RW-1:0]    rs2;
    logic [WIDTH-1:0] imm;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] acc_out;
    logic             carry_flag;
    logic             zero_flag;

    modport master (
        output start, op, rd, rs1, rs2, imm,
        input  busy, done, acc_out, carry_flag, zero_flag
    );

    modport slave (
        input  start, op, rd, rs1, rs2, imm,
        output busy, done, acc_out, carry_flag, zero_flag
    );
endinterface

// File: rtl/serial_exec_unit.sv
// Bit-serial ALU with a small register file, one result bit per cycle.
// Define SERIAL_EXEC_FLAGS_EN to build the carry/zero status flags.
module serial_exec_unit #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
) (
    input logic          clk,
    input logic          rst_n,
    serial_exec_unit_if.slave bus
);
    localparam int RW = $clog2(NREGS);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_MOV = 3'd5;
    localparam logic [2:0] OP_LI  = 3'd6;
    localparam logic [2:0] OP_RSV = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WB
    } state_t;

    state_t state;
    state_t state_nx;

    logic             busy;
    logic             done;
    logic             accept;
    logic             last;
    logic [CW-1:0]    cnt;
    logic [2:0]       op_q;
    logic [RW-1:0]    rd_q;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic             cy;
    logic             cy_nx;
    logic             a_bit;
    logic             b_bit;
    logic             r_bit;
    logic             wr_ok;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [WIDTH-1:0] regs [NREGS];

    assign accept = (state == IDLE) && bus.start;
    assign last   = (cnt == CW'(WIDTH - 1));
    assign wr_ok  = (op_q != OP_RSV) && (rd_q != '0)
                 && (int'(rd_q) < NREGS);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: if (bus.start) state_nx = EXEC;
            EXEC: begin
                busy = 1'b1;
                if (last) state_nx = WB;
            end
            WB: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Register 0 and indices past the file read as zero
    always_comb begin
        op1 = '0;
        op2 = '0;
        if (bus.rs1 != '0 && int'(bus.rs1) < NREGS) op1 = regs[bus.rs1];
        if (bus.rs2 != '0 && int'(bus.rs2) < NREGS) op2 = regs[bus.rs2];
    end

    always_comb begin
        a_bit = a_sh[0];
        b_bit = (op_q == OP_SUB) ? ~b_sh[0] : b_sh[0];
        r_bit = 1'b0;
        cy_nx = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB: begin
                r_bit = a_bit ^ b_bit ^ cy;
                cy_nx = (a_bit & b_bit) | (a_bit & cy) | (b_bit & cy);
            end
            OP_AND:        r_bit = a_bit & b_bit;
            OP_OR:         r_bit = a_bit | b_bit;
            OP_XOR:        r_bit = a_bit ^ b_bit;
            OP_MOV, OP_LI: r_bit = a_bit;
            default:       r_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            op_q <= '0;
            rd_q <= '0;
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
            cy   <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (accept) begin
            // LI rides the rs1 path so the serial core treats it like MOV
            op_q <= bus.op;
            rd_q <= bus.rd;
            a_sh <= (bus.op == OP_LI) ? bus.imm : op1;
            b_sh <= op2;
            cy   <= (bus.op == OP_SUB);
            cnt  <= '0;
        end else if (state == EXEC) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            acc  <= {r_bit, acc[WIDTH-1:1]};
            cy   <= cy_nx;
            cnt  <= cnt + 1'b1;
        end else if (state == WB) begin
            if (wr_ok) regs[rd_q] <= acc;
            cnt <= '0;
        end
    end

`ifdef SERIAL_EXEC_FLAGS_EN
    logic carry_q;
    logic zero_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (state == WB) begin
            carry_q <= cy && (op_q == OP_ADD || op_q == OP_SUB);
            zero_q  <= (acc == '0);
        end
    end

    assign bus.carry_flag = carry_q;
    assign bus.zero_flag  = zero_q;
`else
    assign bus.carry_flag = 1'b0;
    assign bus.zero_flag  = 1'b0;
`endif

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.acc_out = acc;
endmodule
